// File: rtl/trivium_decrypt_rx_if.sv
// -----------------------------------------------------------------------------
// trivium_decrypt_rx_if
//   Bundles every non-clock signal of the Trivium receive-side decryptor:
//   - the ciphertext serial line,
//   - the keystream handshake with the local trivium instance,
//   - the plaintext valid/ready output,
//   - the error pulses.
//
//   Modports:
//     slave  - the decryptor itself. It consumes the serial line and the
//              keystream, and produces the plaintext and the error pulses.
//     master - the surrounding environment: line driver, keystream source
//              and plaintext consumer.
//
//   Signals:
//     rx_serial        ciphertext serial line, idle high
//     keystream_byte   current keystream byte
//     keystream_valid  keystream_byte is usable
//     keystream_read   one-cycle pulse, keystream byte consumed
//     pt_data          decrypted plaintext byte
//     pt_valid         pt_data valid, held until accepted
//     pt_ready         consumer accepts pt_data when pt_valid && pt_ready
//     frame_err        one-cycle pulse, bad stop bit (or parity)
//     overrun          one-cycle pulse, held byte discarded by new start bit
// -----------------------------------------------------------------------------
interface trivium_decrypt_rx_if;
   logic       rx_serial;
   logic [7:0] keystream_byte;
   logic       keystream_valid;
   logic       keystream_read;
   logic [7:0] pt_data;
   logic       pt_valid;
   logic       pt_ready;
   logic       frame_err;
   logic       overrun;

   modport slave (
      input  rx_serial,
      input  keystream_byte,
      input  keystream_valid,
      input  pt_ready,
      output keystream_read,
      output pt_data,
      output pt_valid,
      output frame_err,
      output overrun
   );

   modport master (
      output rx_serial,
      output keystream_byte,
      output keystream_valid,
      output pt_ready,
      input  keystream_read,
      input  pt_data,
      input  pt_valid,
      input  frame_err,
      input  overrun
   );
endinterface

// File: rtl/trivium_decrypt_rx.sv
// -----------------------------------------------------------------------------
// trivium_decrypt_rx
//   Receive-side peer of the Trivium UART encryptor.
//   The block works in three steps:
//   1. It deserialises UART ciphertext, 8N1 by default.
//   2. It XORs each received byte with one keystream byte from a local
//      trivium instance.
//   3. It presents the plaintext on a valid/ready output.
//   Exactly one keystream byte is consumed per delivered byte. Dropped and
//   overrun frames consume none.
//
//   Parameters:
//     CLK_FREQ   system clock frequency in Hz
//     BAUD_RATE  serial bit rate. CLKS_PER_BIT = CLK_FREQ / BAUD_RATE.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    trivium_decrypt_rx_if.slave. It carries:
//            - rx_serial,
//            - the keystream handshake,
//            - the plaintext valid/ready output,
//            - the frame_err and overrun pulses.
//
//   Optional feature (macro DECRYPT_PARITY_EN):
//     When defined, the frame is 8E1. A PARITY state checks one even-parity
//     bit over the 8 ciphertext bits. A mismatch still runs the STOP bit;
//     the frame is then reported through frame_err and dropped.
// -----------------------------------------------------------------------------
module trivium_decrypt_rx #(
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic                 clk,
   input  logic                 rst_n,
   trivium_decrypt_rx_if.slave  bus
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

`ifdef DECRYPT_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_PARITY  = 3'd3,
      ST_STOP    = 3'd4,
      ST_DECRYPT = 3'd5
   } state_t;

   // Even parity: the parity bit equals the XOR of the data bits.
   function automatic logic parity_even(input logic [7:0] data);
      return ^data;
   endfunction
`else
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd4,
      ST_DECRYPT = 3'd5
   } state_t;
`endif

   state_t           state_q,     state_d;
   logic             rx_meta_q;
   logic             rxs_q;
   logic [CNT_W-1:0] baud_cnt_q,  baud_cnt_d;
   logic [2:0]       bit_cnt_q,   bit_cnt_d;
   logic [7:0]       shift_q,     shift_d;
   logic [7:0]       pt_data_q,   pt_data_d;
   logic             pt_valid_q,  pt_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q,   overrun_d;
   logic             ks_read_s;
   logic             hold_s;
   logic             stop_ok_s;
`ifdef DECRYPT_PARITY_EN
   logic             par_err_q,   par_err_d;
`endif

   // Two-flop synchroniser for the asynchronous serial line. It resets to
   // the idle level, so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= bus.rx_serial;
         rxs_q     <= rx_meta_q;
      end
   end

   // State register and datapath flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         baud_cnt_q  <= CNT_ZERO;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         pt_data_q   <= 8'h00;
         pt_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef DECRYPT_PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         pt_data_q   <= pt_data_d;
         pt_valid_q  <= pt_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef DECRYPT_PARITY_EN
         par_err_q   <= par_err_d;
`endif
      end
   end

   // Next-state logic and outputs for the receive/decrypt FSM.
   always_comb begin
      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      pt_data_d   = pt_data_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      ks_read_s   = 1'b0;
`ifdef DECRYPT_PARITY_EN
      par_err_d   = par_err_q;
      stop_ok_s   = rxs_q && !par_err_q;
`else
      stop_ok_s   = rxs_q;
`endif

      // An accepted byte frees the output register. A load in the same
      // cycle (below) overrides this, so pt_valid stays high with new data.
      hold_s = pt_valid_q && !bus.pt_ready;
      if (pt_valid_q && bus.pt_ready) begin
         pt_valid_d = 1'b0;
      end else begin
         pt_valid_d = pt_valid_q;
      end

      case (state_q)
         ST_IDLE: begin
            baud_cnt_d = CNT_ZERO;
            bit_cnt_d  = 3'd0;
            if (!rxs_q) begin
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end

         // Re-check the line in mid start bit. A high level here was a glitch.
         ST_START: begin
            if (baud_cnt_q == HALF_LAST) begin
               baud_cnt_d = CNT_ZERO;
               if (!rxs_q) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + CNT_ONE;
            end
         end

         // Sample each data bit in its middle, LSB first.
         ST_DATA: begin
            if (baud_cnt_q == BIT_LAST) begin
               baud_cnt_d = CNT_ZERO;
               shift_d    = {rxs_q, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  bit_cnt_d = 3'd0;
`ifdef DECRYPT_PARITY_EN
                  state_d   = ST_PARITY;
`else
                  state_d   = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  state_d   = ST_DATA;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + CNT_ONE;
            end
         end

`ifdef DECRYPT_PARITY_EN
         // The parity result is only acted on after the stop bit, so a bad
         // frame is consumed in full before it is reported.
         ST_PARITY: begin
            if (baud_cnt_q == BIT_LAST) begin
               baud_cnt_d = CNT_ZERO;
               par_err_d  = rxs_q ^ parity_even(shift_q);
               state_d    = ST_STOP;
            end else begin
               baud_cnt_d = baud_cnt_q + CNT_ONE;
            end
         end
`endif

         ST_STOP: begin
            if (baud_cnt_q == BIT_LAST) begin
               baud_cnt_d = CNT_ZERO;
               if (stop_ok_s) begin
                  state_d = ST_DECRYPT;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + CNT_ONE;
            end
         end

         // A new start bit beats a pending load. The line is high when this
         // state is entered, so any low level here is a fresh falling edge.
         ST_DECRYPT: begin
            if (!rxs_q) begin
               overrun_d  = 1'b1;
               baud_cnt_d = CNT_ZERO;
               state_d    = ST_START;
            end else if (bus.keystream_valid && !hold_s) begin
               pt_data_d  = shift_q ^ bus.keystream_byte;
               pt_valid_d = 1'b1;
               ks_read_s  = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_DECRYPT;
            end
         end

         default: begin
            baud_cnt_d = CNT_ZERO;
            bit_cnt_d  = 3'd0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   // keystream_read is a same-cycle strobe. The keystream source advances
   // on the edge that captures the byte. The strobe is qualified by
   // keystream_valid, so it never fires on an unusable byte.
   assign bus.keystream_read = ks_read_s;
   assign bus.pt_data        = pt_data_q;
   assign bus.pt_valid       = pt_valid_q;
   assign bus.frame_err      = frame_err_q;
   assign bus.overrun        = overrun_q;

endmodule

// File: tb/tb_trivium_decrypt_rx.sv
// -----------------------------------------------------------------------------
// tb_trivium_decrypt_rx
//   Self-checking bench for trivium_decrypt_rx, with CLKS_PER_BIT = 10.
//
//   The keystream is a table, ks_arr. Its index advances on each
//   keystream_read, like a free-running trivium. Plaintext expectations come
//   from a queue of ciphertext bytes that should be delivered. The k-th
//   delivered byte must equal ciphertext[k] ^ ks_arr[k].
// -----------------------------------------------------------------------------
module tb_trivium_decrypt_rx;

   localparam int CLK_FREQ  = 1000000;
   localparam int BAUD_RATE = 100000;
   localparam int CPB       = CLK_FREQ / BAUD_RATE;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   trivium_decrypt_rx_if bus_if();

   trivium_decrypt_rx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int         n_compared   = 0;
   int         n_mismatched = 0;

   logic [7:0] ks_arr [0:63];
   int         ks_idx       = 0;
   int         deliv_idx    = 0;
   logic [7:0] exp_q [$];
   logic [7:0] last_pt      = 8'h00;

   int         n_ks_reads   = 0;
   int         n_frame_errs = 0;
   int         n_overruns   = 0;
   int         n_pv_cycles  = 0;

   int         fe0, ov0, ks0, pv0, dl0;

   bit         ks_mode      = 1'b0;
   bit         ks_valid_set = 1'b1;
   bit         rdy_mode     = 1'b0;
   bit         rdy_set      = 1'b1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      fe0 = n_frame_errs;
      ov0 = n_overruns;
      ks0 = n_ks_reads;
      pv0 = n_pv_cycles;
      dl0 = deliv_idx;
   endtask

   task automatic send_bit(input logic v);
      bus_if.rx_serial = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef DECRYPT_PARITY_EN
      send_bit((^b) ^ par_flip);
`endif
      send_bit(stop_bit);
      bus_if.rx_serial = 1'b1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || bus_if.pt_valid) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq(tag, exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Keystream source: advance on each consumed byte, then present the next one.
   initial begin
      bit rd;
      forever begin
         @(negedge clk);
         rd = bus_if.keystream_read;
         @(posedge clk);
         #1;
         if (rd) ks_idx++;
         bus_if.keystream_byte = ks_arr[ks_idx % 64];
         if (ks_mode) bus_if.keystream_valid = ($urandom_range(0, 3) != 0);
         else         bus_if.keystream_valid = ks_valid_set;
      end
   end

   // Plaintext consumer ready.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode) bus_if.pt_ready = ($urandom_range(0, 1) != 0);
         else          bus_if.pt_ready = rdy_set;
      end
   end

   // Monitor: scoreboard, pulse counters and output invariants.
   initial begin
      bit         held_prev = 1'b0;
      logic [7:0] held_data = 8'h00;
      logic [7:0] exp_pt;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus_if.keystream_read) begin
               n_ks_reads++;
               check_eq("ks_read_needs_valid", bus_if.keystream_valid, 1);
            end
            if (bus_if.frame_err) n_frame_errs++;
            if (bus_if.overrun)   n_overruns++;
            if (bus_if.pt_valid)  n_pv_cycles++;
            if (held_prev) begin
               check_eq("hold_valid", bus_if.pt_valid, 1);
               check_eq("hold_data", bus_if.pt_data, held_data);
            end
            if (bus_if.pt_valid && bus_if.pt_ready) begin
               check_eq("pt_pending", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  exp_pt = exp_q.pop_front() ^ ks_arr[deliv_idx % 64];
                  check_eq("pt_data", bus_if.pt_data, exp_pt);
                  deliv_idx++;
                  last_pt = bus_if.pt_data;
               end
            end
            held_prev = bus_if.pt_valid && !bus_if.pt_ready;
            held_data = bus_if.pt_data;
         end else begin
            held_prev = 1'b0;
         end
      end
   end

   initial begin
      logic [7:0] b;
      bus_if.rx_serial       = 1'b1;
      bus_if.keystream_byte  = 8'h00;
      bus_if.keystream_valid = 1'b0;
      bus_if.pt_ready        = 1'b0;
      for (int i = 0; i < 64; i++) ks_arr[i] = 8'($urandom);

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_pt_valid",  bus_if.pt_valid, 0);
      check_eq("rst_pt_data",   bus_if.pt_data, 0);
      check_eq("rst_ks_read",   bus_if.keystream_read, 0);
      check_eq("rst_frame_err", bus_if.frame_err, 0);
      check_eq("rst_overrun",   bus_if.overrun, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // 1: basic decrypt
      snap();
      ks_arr[ks_idx % 64] = 8'h3C;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0);
      drain("t1_drain");
      check_eq("t1_pt", last_pt, 8'h99);
      check_eq("t1_pv_cycles", n_pv_cycles - pv0, 1);
      check_eq("t1_ks_reads", n_ks_reads - ks0, 1);

      // 2: keystream not valid for 50 clocks
      snap();
      ks_valid_set = 1'b0;
      ks_arr[ks_idx % 64] = 8'h41;
      exp_q.push_back(8'h41);
      send_frame(8'h41, 1'b1, 1'b0);
      repeat (50) @(posedge clk);
      #1;
      check_eq("t2_wait_no_pv", n_pv_cycles - pv0, 0);
      check_eq("t2_wait_no_read", n_ks_reads - ks0, 0);
      ks_valid_set = 1'b1;
      drain("t2_drain");
      check_eq("t2_pt", last_pt, 8'h00);
      check_eq("t2_ks_reads", n_ks_reads - ks0, 1);

      // 3: bad stop bit
      snap();
      send_frame(8'h5C, 1'b0, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      check_eq("t3_frame_err", n_frame_errs - fe0, 1);
      check_eq("t3_no_pv", n_pv_cycles - pv0, 0);
      check_eq("t3_no_read", n_ks_reads - ks0, 0);

      // 4: held output, second byte waits, third byte overruns it
      snap();
      rdy_set = 1'b0;
      ks_arr[ks_idx % 64]       = 8'h00;
      ks_arr[(ks_idx + 1) % 64] = 8'h00;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h33);
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      send_frame(8'h33, 1'b1, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      check_eq("t4_held_valid", bus_if.pt_valid, 1);
      check_eq("t4_held_data", bus_if.pt_data, 8'h11);
      check_eq("t4_overrun", n_overruns - ov0, 1);
      check_eq("t4_ks_reads_held", n_ks_reads - ks0, 1);
      rdy_set = 1'b1;
      drain("t4_drain");
      check_eq("t4_ks_reads", n_ks_reads - ks0, 2);
      check_eq("t4_delivered", deliv_idx - dl0, 2);
      check_eq("t4_last_pt", last_pt, 8'h33);

      // 5: three-clock glitch
      snap();
      bus_if.rx_serial = 1'b0;
      repeat (3) @(posedge clk);
      #1 bus_if.rx_serial = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check_eq("t5_no_fe", n_frame_errs - fe0, 0);
      check_eq("t5_no_ov", n_overruns - ov0, 0);
      check_eq("t5_no_pv", n_pv_cycles - pv0, 0);
      check_eq("t5_no_read", n_ks_reads - ks0, 0);

      // 6: reset mid-DATA, then a clean frame
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("t6_rst_pt_valid",  bus_if.pt_valid, 0);
      check_eq("t6_rst_pt_data",   bus_if.pt_data, 0);
      check_eq("t6_rst_ks_read",   bus_if.keystream_read, 0);
      check_eq("t6_rst_frame_err", bus_if.frame_err, 0);
      check_eq("t6_rst_overrun",   bus_if.overrun, 0);
      bus_if.rx_serial = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      snap();
      ks_arr[ks_idx % 64] = 8'hFF;
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, 1'b0);
      drain("t6_drain");
      check_eq("t6_pt", last_pt, 8'hA5);
      check_eq("t6_ks_reads", n_ks_reads - ks0, 1);

`ifdef DECRYPT_PARITY_EN
      // Wrong parity bit
      snap();
      send_frame(8'h6B, 1'b1, 1'b1);
      repeat (30) @(posedge clk);
      #1;
      check_eq("par_frame_err", n_frame_errs - fe0, 1);
      check_eq("par_no_read", n_ks_reads - ks0, 0);
      check_eq("par_no_pv", n_pv_cycles - pv0, 0);
`endif

      // Randomised traffic with random keystream stalls and consumer back-pressure
      ks_mode  = 1'b1;
      rdy_mode = 1'b1;
      for (int f = 0; f < 16; f++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         send_frame(b, 1'b1, 1'b0);
         drain("rnd_drain");
         repeat ($urandom_range(0, 15)) @(posedge clk);
         #1;
      end
      ks_mode  = 1'b0;
      rdy_mode = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_eq("ks_vs_delivered", ks_idx, deliv_idx);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
